// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and constants for the hazard scoreboard.
//
// Contents:
//   AW_MAX         widest register address the scoreboard entry can hold
//   FWD_REGFILE    forward-select value meaning "take operand from the register file"
//   sb_entry_t     one in-flight instruction tracked after decode
//   params_legal   elaboration-time parameter legality check
//
// Configuration macro used by the including design: HZ_FORWARD_EN.
package hazard_pkg;

  localparam int AW_MAX      = 8;
  localparam int FWD_REGFILE = 0;

  // Register fields are stored at AW_MAX bits; narrower address widths are
  // zero-extended on the way in so that comparisons stay exact.
  typedef struct packed {
    logic              valid;
    logic              arm;
    logic [AW_MAX-1:0] rd;
    logic              regwrite;
    logic              load;
    logic [AW_MAX-1:0] rs1;
    logic [AW_MAX-1:0] rs2;
    logic              rs1_use;
    logic              rs2_use;
  } sb_entry_t;

  function automatic bit params_legal(input int nstages, input int aw, input int load_avail);
    return (nstages >= 2) && (nstages <= 8) &&
           (aw >= 1) && (aw <= AW_MAX) &&
           (load_avail >= 1) && (load_avail <= nstages - 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match -- compares one source register against every scoreboard entry.
//
// Ports:
//   valid, regwrite, load  in  NSTAGES  per-entry flags (entry 0 = E)
//   rd                     in  AW_MAX x NSTAGES  per-entry destination
//   src                    in  AW_MAX  source register being read
//   src_use                in  1       source is actually read (and consumer valid)
//   arm                    in  1       consumer is ARM; 0 = RISC-V, where x0 never matches
//   hit                    out NSTAGES raw match per entry
//   fwd_idx                out FW      youngest forwardable producer in 1..NSTAGES-1, else 0
//
// A load producer is only forwardable from entry LOAD_AVAIL onward.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int FW         = 2
) (
  input  logic [NSTAGES-1:0] valid,
  input  logic [NSTAGES-1:0] regwrite,
  input  logic [NSTAGES-1:0] load,
  input  logic [AW_MAX-1:0]  rd [NSTAGES],
  input  logic [AW_MAX-1:0]  src,
  input  logic               src_use,
  input  logic               arm,
  output logic [NSTAGES-1:0] hit,
  output logic [FW-1:0]      fwd_idx
);

  logic found;
  logic unused_load0;

  // Entry 0 is the consumer's own stage for forwarding, so its load flag is
  // never consulted here.
  assign unused_load0 = load[0];

  always_comb begin
    hit = '0;
    for (int j = 0; j < NSTAGES; j++) begin
      hit[j] = valid[j] & regwrite[j] & src_use & (rd[j] == src) &
               (arm | (src != '0));
    end
  end

  // Ascending scan: the first qualifying entry is the youngest producer.
  always_comb begin
    fwd_idx = FW'(FWD_REGFILE);
    found   = 1'b0;
    for (int j = 1; j < NSTAGES; j++) begin
      if (!found && hit[j] && (!load[j] || (j >= LOAD_AVAIL))) begin
        fwd_idx = FW'(j);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- parametrised hazard unit for the ARM/RISC-V pipeline.
//
// Keeps a shadow scoreboard of every post-decode stage (entry 0 = E,
// entry NSTAGES-1 = W) and derives stalls, flushes and forward selects.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_d, arm_d           decode holds an instruction / instruction is ARM
//   rs1_d, rs2_d             decode sources; rs1_use_d, rs2_use_d: actually read
//   rd_d, regwrite_d, load_d decode destination, writes it, result from memory
//   branch_taken_e           execute redirects the PC
//   stall_f, stall_d         hold PC / decode register
//   flush_d, flush_e         bubble decode / execute register
//   fwd_a, fwd_b             execute operand source (0 = regfile, j = entry j)
//   stall_cnt                saturating count of hazard stall cycles
//
// Macro HZ_FORWARD_EN: when defined, results are forwarded and only
// too-young load results stall. When undefined, nothing is forwarded and
// any in-flight producer in entries 0..NSTAGES-2 stalls decode.
//
// Valid/ready: there is no handshake; decode simply offers one instruction
// per cycle and obeys stall_d/flush_d in the same cycle, and the downstream
// pipeline always advances.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGES    = 3,
  parameter int AW         = 5,
  parameter int LOAD_AVAIL = 2,
  parameter int FW         = $clog2(NSTAGES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_d,
  input  logic          arm_d,
  input  logic [AW-1:0] rs1_d,
  input  logic [AW-1:0] rs2_d,
  input  logic          rs1_use_d,
  input  logic          rs2_use_d,
  input  logic [AW-1:0] rd_d,
  input  logic          regwrite_d,
  input  logic          load_d,
  input  logic          branch_taken_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_d,
  output logic          flush_e,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [31:0]   stall_cnt
);

  if (!params_legal(NSTAGES, AW, LOAD_AVAIL)) begin : g_bad_params
    $error("hazard_scoreboard: illegal NSTAGES/AW/LOAD_AVAIL combination");
  end

  sb_entry_t          sb [NSTAGES];
  sb_entry_t          dec_entry;
  logic [NSTAGES-1:0] sb_valid;
  logic [NSTAGES-1:0] sb_regwrite;
  logic [NSTAGES-1:0] sb_load;
  logic [AW_MAX-1:0]  sb_rd [NSTAGES];
  logic [NSTAGES-1:0] dec_hit_a;
  logic [NSTAGES-1:0] dec_hit_b;
  logic [FW-1:0]      dec_fwd_a;
  logic [FW-1:0]      dec_fwd_b;
  logic [FW-1:0]      exe_fwd_a;
  logic [FW-1:0]      exe_fwd_b;
  logic               load_hazard;

  always_comb begin
    dec_entry          = '0;
    dec_entry.valid    = valid_d;
    dec_entry.arm      = arm_d;
    dec_entry.rd       = AW_MAX'(rd_d);
    dec_entry.regwrite = regwrite_d;
    dec_entry.load     = load_d;
    dec_entry.rs1      = AW_MAX'(rs1_d);
    dec_entry.rs2      = AW_MAX'(rs2_d);
    dec_entry.rs1_use  = rs1_use_d;
    dec_entry.rs2_use  = rs2_use_d;
  end

  always_comb begin
    sb_valid    = '0;
    sb_regwrite = '0;
    sb_load     = '0;
    for (int j = 0; j < NSTAGES; j++) begin
      sb_valid[j]    = sb[j].valid;
      sb_regwrite[j] = sb[j].regwrite;
      sb_load[j]     = sb[j].load;
      sb_rd[j]       = sb[j].rd;
    end
  end

  // Decode-side comparators: the consumer is the instruction in decode.
  hazard_match #(.NSTAGES(NSTAGES), .LOAD_AVAIL(LOAD_AVAIL), .FW(FW)) u_dec_a (
    .valid(sb_valid), .regwrite(sb_regwrite), .load(sb_load), .rd(sb_rd),
    .src(dec_entry.rs1), .src_use(valid_d & rs1_use_d), .arm(arm_d),
    .hit(dec_hit_a), .fwd_idx(dec_fwd_a)
  );

  hazard_match #(.NSTAGES(NSTAGES), .LOAD_AVAIL(LOAD_AVAIL), .FW(FW)) u_dec_b (
    .valid(sb_valid), .regwrite(sb_regwrite), .load(sb_load), .rd(sb_rd),
    .src(dec_entry.rs2), .src_use(valid_d & rs2_use_d), .arm(arm_d),
    .hit(dec_hit_b), .fwd_idx(dec_fwd_b)
  );

`ifdef HZ_FORWARD_EN
  logic [NSTAGES-1:0] exe_hit_a;
  logic [NSTAGES-1:0] exe_hit_b;
  logic               unused_fwd;

  // Execute-side comparators: the consumer is scoreboard entry 0 itself.
  hazard_match #(.NSTAGES(NSTAGES), .LOAD_AVAIL(LOAD_AVAIL), .FW(FW)) u_exe_a (
    .valid(sb_valid), .regwrite(sb_regwrite), .load(sb_load), .rd(sb_rd),
    .src(sb[0].rs1), .src_use(sb[0].valid & sb[0].rs1_use), .arm(sb[0].arm),
    .hit(exe_hit_a), .fwd_idx(exe_fwd_a)
  );

  hazard_match #(.NSTAGES(NSTAGES), .LOAD_AVAIL(LOAD_AVAIL), .FW(FW)) u_exe_b (
    .valid(sb_valid), .regwrite(sb_regwrite), .load(sb_load), .rd(sb_rd),
    .src(sb[0].rs2), .src_use(sb[0].valid & sb[0].rs2_use), .arm(sb[0].arm),
    .hit(exe_hit_b), .fwd_idx(exe_fwd_b)
  );

  assign unused_fwd = ^{dec_fwd_a, dec_fwd_b, exe_hit_a, exe_hit_b,
                        dec_hit_a[NSTAGES-1], dec_hit_b[NSTAGES-1]};

  // Only a load still younger than LOAD_AVAIL blocks the consumer.
  always_comb begin
    load_hazard = 1'b0;
    for (int j = 0; j < NSTAGES - 1; j++) begin
      if ((dec_hit_a[j] | dec_hit_b[j]) && sb_load[j] && (j + 1 < LOAD_AVAIL)) begin
        load_hazard = 1'b1;
      end
    end
  end
`else
  logic unused_fwd;

  assign exe_fwd_a  = FW'(FWD_REGFILE);
  assign exe_fwd_b  = FW'(FWD_REGFILE);
  assign unused_fwd = ^{dec_fwd_a, dec_fwd_b, sb[0].rs1, sb[0].rs2,
                        sb[0].rs1_use, sb[0].rs2_use, sb[0].arm,
                        dec_hit_a[NSTAGES-1], dec_hit_b[NSTAGES-1]};

  // Without forwarding every producer short of W blocks the consumer.
  always_comb begin
    load_hazard = 1'b0;
    for (int j = 0; j < NSTAGES - 1; j++) begin
      if (dec_hit_a[j] | dec_hit_b[j]) begin
        load_hazard = 1'b1;
      end
    end
  end
`endif

  // A taken branch squashes the stalled consumer anyway, so it overrides the stall.
  always_comb begin
    stall_f = load_hazard & ~branch_taken_e;
    stall_d = load_hazard & ~branch_taken_e;
    flush_d = branch_taken_e;
    flush_e = branch_taken_e | load_hazard;
    fwd_a   = exe_fwd_a;
    fwd_b   = exe_fwd_b;
    if (rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      fwd_a   = FW'(FWD_REGFILE);
      fwd_b   = FW'(FWD_REGFILE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NSTAGES; j++) begin
        sb[j] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      sb[0] <= flush_e ? '0 : dec_entry;
      for (int j = 1; j < NSTAGES; j++) begin
        sb[j] <= sb[j-1];
      end
      if (stall_d && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard -- directed plus random checks of hazard_scoreboard.
// Two instances share the decode inputs: the default configuration
// (NSTAGES=3, LOAD_AVAIL=2) and a deep one (NSTAGES=5, LOAD_AVAIL=4).
// Each is compared every cycle against a queue-based model of the
// in-flight instruction list.
module tb_hazard_scoreboard;

`ifdef HZ_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    bit valid;
    bit arm;
    int rd;
    bit rw;
    bit ld;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } instr_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       valid_d, arm_d, rs1_use_d, rs2_use_d, regwrite_d, load_d, branch_taken_e;
  logic [4:0] rs1_d, rs2_d, rd_d;

  logic        stall_f0, stall_d0, flush_d0, flush_e0;
  logic [1:0]  fwd_a0, fwd_b0;
  logic [31:0] cnt0;
  logic        stall_f1, stall_d1, flush_d1, flush_e1;
  logic [2:0]  fwd_a1, fwd_b1;
  logic [31:0] cnt1;

  hazard_scoreboard dut0 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .arm_d(arm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
    .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f0), .stall_d(stall_d0), .flush_d(flush_d0), .flush_e(flush_e0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.NSTAGES(5), .AW(5), .LOAD_AVAIL(4)) dut1 (
    .clk(clk), .rst(rst), .valid_d(valid_d), .arm_d(arm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
    .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d),
    .branch_taken_e(branch_taken_e),
    .stall_f(stall_f1), .stall_d(stall_d1), .flush_d(flush_d1), .flush_e(flush_e1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cnt(cnt1)
  );

  // scoreboard state
  int unsigned total = 0;
  int unsigned bad   = 0;
  instr_t      q0[$];
  instr_t      q1[$];
  longint      mcnt0 = 0;
  longint      mcnt1 = 0;
  bit          obs_st0, obs_st1;

  function automatic bit m_match(input instr_t p, input int src, input bit use_src, input bit carm);
    return p.valid && p.rw && use_src && (p.rd == src) && !(!carm && src == 0);
  endfunction

  // Model: stall if decode reads a producer that cannot yet supply it;
  // forward from the youngest producer that can.
  function automatic void model_eval(input instr_t q[$], input int ns, input int la,
                                     input instr_t d, input bit rst_i, input bit bt,
                                     output bit st, output bit fd, output bit fe,
                                     output int fa, output int fb);
    bit lh = 1'b0;
    fa = 0;
    fb = 0;
    if (d.valid) begin
      for (int j = 0; j <= ns - 2 && j < q.size(); j++) begin
        if ((m_match(q[j], d.rs1, d.u1, d.arm) || m_match(q[j], d.rs2, d.u2, d.arm)) &&
            (!FWD_ON || (q[j].ld && (j + 1 < la))))
          lh = 1'b1;
      end
    end
    if (FWD_ON && q.size() > 0 && q[0].valid) begin
      for (int j = 1; j < ns && j < q.size(); j++) begin
        if (fa == 0 && m_match(q[j], q[0].rs1, q[0].u1, q[0].arm) && (!q[j].ld || j >= la)) fa = j;
        if (fb == 0 && m_match(q[j], q[0].rs2, q[0].u2, q[0].arm) && (!q[j].ld || j >= la)) fb = j;
      end
    end
    st = lh && !bt;
    fd = bt;
    fe = bt || lh;
    if (rst_i) begin
      st = 1'b0; fd = 1'b1; fe = 1'b1; fa = 0; fb = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_instr(input bit v, input bit a, input int rd, input bit rw, input bit ld,
                           input int r1, input bit u1, input int r2, input bit u2);
    valid_d = v; arm_d = a; rd_d = 5'(rd); regwrite_d = rw; load_d = ld;
    rs1_d = 5'(r1); rs1_use_d = u1; rs2_d = 5'(r2); rs2_use_d = u2;
  endtask

  task automatic set_nop();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One cycle: check mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    instr_t d, bubble;
    bit st0, fd0, fe0, st1, fd1, fe1;
    int fa0, fb0, fa1, fb1;
    #2;
    bubble = '{default: 0};
    d = '{valid: valid_d, arm: arm_d, rd: int'(rd_d), rw: regwrite_d, ld: load_d,
          rs1: int'(rs1_d), rs2: int'(rs2_d), u1: rs1_use_d, u2: rs2_use_d};
    model_eval(q0, 3, 2, d, rst, branch_taken_e, st0, fd0, fe0, fa0, fb0);
    model_eval(q1, 5, 4, d, rst, branch_taken_e, st1, fd1, fe1, fa1, fb1);
    obs_st0 = stall_d0;
    obs_st1 = stall_d1;
    chk("d3_stall_f", 32'(stall_f0), 32'(st0));
    chk("d3_stall_d", 32'(stall_d0), 32'(st0));
    chk("d3_flush_d", 32'(flush_d0), 32'(fd0));
    chk("d3_flush_e", 32'(flush_e0), 32'(fe0));
    chk("d3_fwd_a", 32'(fwd_a0), 32'(fa0));
    chk("d3_fwd_b", 32'(fwd_b0), 32'(fb0));
    chk("d3_stall_cnt", cnt0, mcnt0[31:0]);
    chk("d5_stall_f", 32'(stall_f1), 32'(st1));
    chk("d5_stall_d", 32'(stall_d1), 32'(st1));
    chk("d5_flush_d", 32'(flush_d1), 32'(fd1));
    chk("d5_flush_e", 32'(flush_e1), 32'(fe1));
    chk("d5_fwd_a", 32'(fwd_a1), 32'(fa1));
    chk("d5_fwd_b", 32'(fwd_b1), 32'(fb1));
    chk("d5_stall_cnt", cnt1, mcnt1[31:0]);
    @(posedge clk);
    if (rst) begin
      q0.delete(); q1.delete(); mcnt0 = 0; mcnt1 = 0;
    end else begin
      if (st0 && mcnt0 < 64'hFFFF_FFFF) mcnt0++;
      if (st1 && mcnt1 < 64'hFFFF_FFFF) mcnt1++;
      q0.push_front(fe0 ? bubble : d);
      q1.push_front(fe1 ? bubble : d);
      while (q0.size() > 3) void'(q0.pop_back());
      while (q1.size() > 5) void'(q1.pop_back());
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Hold the current decode instruction while the chosen DUT stalls (bounded).
  task automatic hold(input bit deep, output int n);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (deep ? obs_st1 : obs_st0) n++;
      else break;
    end
  endtask

  int n;

  initial begin
    rst = 1'b1;
    branch_taken_e = 1'b0;
    set_instr(1, 0, 1, 1, 0, 1, 1, 2, 1);
    @(posedge clk);
    #1;

    // reset held three cycles with a live decode instruction
    do_reset(3);
    chk("rst_cnt0", cnt0, 32'd0);
    set_nop();
    step();
    step();
    chk("idle_flush_e", 32'(flush_e0), 32'd0);
    chk("idle_fwd_a", 32'(fwd_a0), 32'd0);

    // ALU chain: back-to-back, then with one gap
    set_instr(1, 0, 5, 1, 0, 1, 1, 2, 1); step();
    set_instr(1, 0, 6, 1, 0, 5, 1, 3, 1); hold(0, n);
    set_nop(); step(); step(); step();
    set_instr(1, 0, 5, 1, 0, 1, 1, 2, 1); step();
    set_nop(); step();
    set_instr(1, 0, 6, 1, 0, 3, 1, 5, 1); hold(0, n);
    set_nop(); step(); step(); step();

    // load-use on the default instance
    do_reset(1);
    set_instr(1, 0, 7, 1, 1, 1, 1, 2, 0); step();
    set_instr(1, 0, 8, 1, 0, 7, 1, 0, 0); hold(0, n);
    chk("lu_stall_cycles", 32'(n), FWD_ON ? 32'd1 : 32'd2);
    chk("lu_stall_cnt", cnt0, FWD_ON ? 32'd1 : 32'd2);
    set_nop(); step(); step(); step();

    // register 0: RISC-V x0 never hazards, ARM r0 does
    set_instr(1, 0, 0, 1, 0, 1, 1, 2, 1); step();
    set_instr(1, 0, 9, 1, 0, 0, 1, 0, 1); hold(0, n);
    set_nop(); step(); step(); step();
    set_instr(1, 1, 0, 1, 0, 1, 1, 2, 1); step();
    set_instr(1, 1, 9, 1, 0, 0, 1, 3, 0); hold(0, n);
    set_nop(); step(); step(); step();

    // branch in the same cycle as a load hazard
    do_reset(1);
    set_instr(1, 0, 7, 1, 1, 1, 1, 2, 0); step();
    set_instr(1, 0, 8, 1, 0, 2, 0, 7, 1);
    branch_taken_e = 1'b1;
    step();
    branch_taken_e = 1'b0;
    chk("br_stall_cnt", cnt0, 32'd0);
    set_nop(); step(); step();

    // deep instance: load then dependent consumer
    do_reset(1);
    set_instr(1, 0, 3, 1, 1, 1, 0, 2, 0); step();
    set_instr(1, 0, 4, 1, 0, 1, 0, 3, 1); hold(1, n);
    chk("deep_stall_cycles", 32'(n), FWD_ON ? 32'd3 : 32'd4);
    set_nop(); step(); step(); step(); step(); step();

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      branch_taken_e = ($urandom_range(0, 7) == 0);
      set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
      step();
    end
    rst = 1'b0;
    branch_taken_e = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
